// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
// Holds the state encoding, decoder op classes, writeback sources and trap causes.
// Also has one helper that classifies memory ops.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [4:0] OP_JAL     = 5'b10000;
  localparam logic [4:0] OP_BEQ     = 5'b10001;
  localparam logic [4:0] OP_BLT     = 5'b10010;
  localparam logic [4:0] OP_LW      = 5'b10100;
  localparam logic [4:0] OP_SW      = 5'b10101;
  localparam logic [4:0] OP_ILLEGAL = 5'b00000;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_FETCH   = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_DATA    = 2'd3;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts cycles a memory request has waited for its ack; flags the last allowed cycle.
// Latency: timeout is combinational from the count; the count updates one cycle after en/clr.
// Backpressure: none; clr has priority over en. MEM_TIMEOUT=0 freezes the count and never flags.
// Ports: clk, rst (async active-low), clr, en, timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr)
      wait_cnt_d = '0;
    else if (en && (MEM_TIMEOUT > 0))
      wait_cnt_d = wait_cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt_q <= '0;
    else
      wait_cnt_q <= wait_cnt_d;
  end

  assign timeout = (MEM_TIMEOUT > 0) && (wait_cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: sequences one RV32I instruction at a time through BOOT/FETCH/DECODE/EXEC/MEM/WB, halting in TRAP.
// Latency: ALU/jal 4 cycles, branch 3, lw 5, sw 4 (ack in the first request cycle); strobes are combinational.
// Backpressure: FETCH/MEM hold their request until ack; MEM_TIMEOUT cycles without ack traps the core.
// Ports: clk, rst (async active-low); decoder alu_op/branch/write_reg; imem/dmem req-ack; PC/IR/RF strobes;
//        halt/trap_cause; state_o debug. Optional PERF_CNT_EN macro adds the cycles/instret counters.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alu_op,
  input  logic        branch,
  input  logic        write_reg,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        halt,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o,
  output logic [31:0] instret,
  output logic [31:0] cycles
);
  import ctrl_pkg::*;

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       branch_q, branch_d;
  logic       write_reg_q, write_reg_d;
  logic [1:0] trap_cause_q, trap_cause_d;

  // One timer serves both request states; it restarts whenever the
  // request completes or the FSM is outside FETCH/MEM.
  logic req_wait, req_ack, mem_timeout;
  assign req_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign req_ack  = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!req_wait || req_ack),
    .en      (req_wait && !req_ack),
    .timeout (mem_timeout)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    branch_d     = branch_q;
    write_reg_d  = write_reg_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        // Ack wins over a timeout landing in the same cycle.
        if (imem_ack)
          state_d = ST_DECODE;
        else if (mem_timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_FETCH;
        end
      end
      ST_DECODE: begin
        op_d        = alu_op;
        branch_d    = branch;
        write_reg_d = write_reg;
        if (alu_op == OP_ILLEGAL) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_mem_op(op_q))
          state_d = ST_MEM;
        else if (branch_q && (op_q != OP_JAL))
          state_d = ST_FETCH;   // beq/blt retire here
        else
          state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack)
          state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
        else if (mem_timeout) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_DATA;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      op_q         <= OP_ILLEGAL;
      branch_q     <= 1'b0;
      write_reg_q  <= 1'b0;
      trap_cause_q <= TRAP_NONE;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      branch_q     <= branch_d;
      write_reg_q  <= write_reg_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    halt     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
      end
      ST_EXEC: begin
        // The decoder has already chosen pc+4 or the target for branches.
        if (branch_q && (op_q != OP_JAL) && !is_mem_op(op_q)) begin
          pc_en  = 1'b1;
          pc_sel = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        pc_en    = dmem_ack && (op_q == OP_SW);
      end
      ST_WB: begin
        rf_we  = write_reg_q;
        pc_en  = 1'b1;
        pc_sel = (op_q == OP_JAL);
        if (op_q == OP_JAL)
          wb_sel = WB_LINK;
        else if (op_q == OP_LW)
          wb_sel = WB_MEM;
      end
      ST_TRAP: halt = 1'b1;
      default: ;
    endcase
  end

  assign trap_cause = trap_cause_q;
  assign state_o    = state_q;

`ifdef PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d, instret_q, instret_d;

  always_comb begin
    cycles_d  = cycles_q;
    instret_d = instret_q;
    if ((state_q != ST_BOOT) && (state_q != ST_TRAP))
      cycles_d = cycles_q + 32'd1;
    if (pc_en)
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
    end
  end

  assign cycles  = cycles_q;
  assign instret = instret_q;
`else
  assign cycles  = '0;
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with MEM_TIMEOUT=8.
// Strobe vector order: {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halt}.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  alu_op = 5'b01100;
  logic        branch = 1'b0;
  logic        write_reg = 1'b1;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halt;
  logic [1:0]  wb_sel, trap_cause;
  logic [2:0]  state_o;
  logic [31:0] instret, cycles;
  logic [7:0]  strb;

  int checks = 0;
  int failures = 0;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .branch(branch), .write_reg(write_reg),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_en(ir_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_en(pc_en), .pc_sel(pc_sel), .halt(halt), .trap_cause(trap_cause),
    .state_o(state_o), .instret(instret), .cycles(cycles)
  );

  assign strb = {imem_req, ir_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, halt};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // FETCH (ack on first cycle) then DECODE; returns one tick into EXEC.
  task automatic issue(input string tag, input logic [4:0] op, input logic br, input logic wr);
    alu_op = op; branch = br; write_reg = wr; imem_ack = 1'b1;
    #1;
    chk({tag, "_fetch_state"}, 32'(state_o), 32'd1);
    chk({tag, "_fetch_strb"}, 32'(strb), 32'h0C0);
    next_cyc();
    imem_ack = 1'b0;
    #1;
    chk({tag, "_decode_state"}, 32'(state_o), 32'd2);
    chk({tag, "_decode_strb"}, 32'(strb), 32'h000);
    next_cyc();
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strb", 32'(strb), 32'h000);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot_state", 32'(state_o), 32'd0);
    chk("boot_strb", 32'(strb), 32'h000);
    next_cyc();

    // addi: F,D,E,WB
    issue("addi", 5'b01100, 1'b0, 1'b1);
    chk("addi_exec_state", 32'(state_o), 32'd3);
    chk("addi_exec_strb", 32'(strb), 32'h000);
    next_cyc(); #1;
    chk("addi_wb_state", 32'(state_o), 32'd5);
    chk("addi_wb_strb", 32'(strb), 32'h00C);
    chk("addi_wb_sel", 32'(wb_sel), 32'd0);
    next_cyc(); #1;
    chk("addi_next_state", 32'(state_o), 32'd1);
    chk("addi_instret", instret, cnt(1));
    chk("addi_cycles", cycles, cnt(4));

    // lw with dmem_ack on the fourth MEM cycle
    issue("lw", 5'b10100, 1'b0, 1'b1);
    chk("lw_exec_strb", 32'(strb), 32'h000);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk("lw_mem_state", 32'(state_o), 32'd4);
      chk("lw_mem_strb", 32'(strb), 32'h020);
      next_cyc();
    end
    dmem_ack = 1'b0;
    #1;
    chk("lw_wb_state", 32'(state_o), 32'd5);
    chk("lw_wb_strb", 32'(strb), 32'h00C);
    chk("lw_wb_sel", 32'(wb_sel), 32'd1);
    next_cyc(); #1;
    chk("lw_next_state", 32'(state_o), 32'd1);

    // sw with immediate dmem_ack
    issue("sw", 5'b10101, 1'b0, 1'b0);
    chk("sw_exec_strb", 32'(strb), 32'h000);
    next_cyc();
    dmem_ack = 1'b1;
    #1;
    chk("sw_mem_state", 32'(state_o), 32'd4);
    chk("sw_mem_strb", 32'(strb), 32'h034);
    next_cyc();
    dmem_ack = 1'b0;
    #1;
    chk("sw_next_state", 32'(state_o), 32'd1);

    // beq retires from EXEC
    issue("beq", 5'b10001, 1'b1, 1'b0);
    chk("beq_exec_state", 32'(state_o), 32'd3);
    chk("beq_exec_strb", 32'(strb), 32'h006);
    next_cyc(); #1;
    chk("beq_next_state", 32'(state_o), 32'd1);

    // jal goes through WB with the link address
    issue("jal", 5'b10000, 1'b1, 1'b1);
    chk("jal_exec_strb", 32'(strb), 32'h000);
    next_cyc(); #1;
    chk("jal_wb_state", 32'(state_o), 32'd5);
    chk("jal_wb_strb", 32'(strb), 32'h00E);
    chk("jal_wb_sel", 32'(wb_sel), 32'd2);
    next_cyc(); #1;
    chk("jal_next_state", 32'(state_o), 32'd1);
    chk("five_instret", instret, cnt(5));
    chk("five_cycles", cycles, cnt(23));

    // Fetch ack on the 8th cycle still decodes
    alu_op = 5'b01100; branch = 1'b0; write_reg = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("late_fetch_state", 32'(state_o), 32'd1);
      chk("late_fetch_strb", 32'(strb), 32'h080);
      next_cyc();
    end
    imem_ack = 1'b1;
    #1;
    chk("late_fetch_ack_strb", 32'(strb), 32'h0C0);
    next_cyc();
    imem_ack = 1'b0;
    #1;
    chk("late_decode_state", 32'(state_o), 32'd2);
    chk("late_cause", 32'(trap_cause), 32'd0);
    next_cyc(); next_cyc(); next_cyc(); #1;
    chk("late_next_state", 32'(state_o), 32'd1);
    chk("late_instret", instret, cnt(6));
    chk("late_cycles", cycles, cnt(34));

    // Illegal instruction traps after DECODE and holds
    issue("ill", 5'b00000, 1'b0, 1'b0);
    chk("ill_trap_state", 32'(state_o), 32'd6);
    chk("ill_trap_cause", 32'(trap_cause), 32'd2);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      #1;
      chk("ill_hold_state", 32'(state_o), 32'd6);
      chk("ill_hold_strb", 32'(strb), 32'h001);
      chk("ill_hold_cause", 32'(trap_cause), 32'd2);
      next_cyc();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("ill_hold_cycles", cycles, cnt(36));
    chk("ill_hold_instret", instret, cnt(6));
    rst = 1'b0;
    #1;
    chk("ill_rst_state", 32'(state_o), 32'd0);
    chk("ill_rst_strb", 32'(strb), 32'h000);
    chk("ill_rst_cause", 32'(trap_cause), 32'd0);
    chk("ill_rst_cycles", cycles, 32'd0);
    chk("ill_rst_instret", instret, 32'd0);

    // Fetch timeout: exactly 8 FETCH cycles without ack
    @(negedge clk);
    rst = 1'b1;
    next_cyc();
    for (int i = 0; i < 8; i++) begin
      chk("ftmo_fetch_state", 32'(state_o), 32'd1);
      next_cyc();
    end
    chk("ftmo_trap_state", 32'(state_o), 32'd6);
    chk("ftmo_trap_cause", 32'(trap_cause), 32'd1);
    chk("ftmo_trap_strb", 32'(strb), 32'h001);

    // Data timeout: lw with no dmem_ack for 8 MEM cycles
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    next_cyc();
    issue("dtmo", 5'b10100, 1'b0, 1'b1);
    next_cyc();
    for (int i = 0; i < 8; i++) begin
      chk("dtmo_mem_state", 32'(state_o), 32'd4);
      next_cyc();
    end
    chk("dtmo_trap_state", 32'(state_o), 32'd6);
    chk("dtmo_trap_cause", 32'(trap_cause), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Sequences the RV32I datapath one instruction at a time through BOOT/FETCH/DECODE/EXEC/MEM/WB.
- Takes class information from the instruction decoder (alu_op, branch, write_reg).
- Drives the PC, IR, register-file write and memory request strobes.
- Applies a req/ack handshake to instruction and data memory, with a wait timeout.
- Illegal instructions and memory timeouts halt the core in TRAP.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request waits for ack before TRAP; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
alu_op  in  5  decoder op code: 10000 jal, 10001 beq, 10010 blt, 10100 lw, 10101 sw, other nonzero = ALU op, 00000 = illegal
branch  in  1  decoder branch flag (jal/beq/blt)
write_reg  in  1  decoder register-write flag
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_en  out  1  IR load strobe
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (sw)
rf_we  out  1  register file write enable
wb_sel  out  2  writeback source: 0 ALU, 1 load data, 2 link address
pc_en  out  1  PC load strobe
pc_sel  out  1  PC source: 0 pc+4, 1 decoder branch address
halt  out  1  core halted in TRAP
trap_cause  out  2  0 none, 1 fetch timeout, 2 illegal instruction, 3 data timeout
state_o  out  3  current state (debug)
instret  out  32  retired-instruction count
cycles  out  32  cycle count

Behaviour:
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (rst low):
  - Takes effect asynchronously: state=BOOT, op_q=0, wait_cnt=0, trap_cause=0, counters=0.
  - All strobes are 0, and halt=0.
- Output timing: all strobes are combinational from the state, op_q and ack. No output is asserted in BOOT.
- BOOT: one cycle after rst is released, then FETCH.
- FETCH: imem_req=1.
  - On imem_ack: ir_en=1 in the same cycle, then DECODE.
  - No ack: wait_cnt increments.
  - Timeout: if wait_cnt==MEM_TIMEOUT-1 with no ack, go to TRAP with cause 1.
  - Ack wins over timeout in the same cycle.
  - wait_cnt clears on leaving FETCH or MEM.
- DECODE: one cycle.
  - Latch alu_op into op_q, and branch and write_reg into flags.
  - alu_op==0: go to TRAP with cause 2. Otherwise go to EXEC.
- EXEC: one cycle.
  - lw or sw: go to MEM.
  - beq or blt: pc_en=1 and pc_sel=1, then FETCH. The decoder already selects pc+4 or the target.
  - jal or ALU op: go to WB.
- MEM: dmem_req=1; dmem_we=1 for sw.
  - On dmem_ack, lw: go to WB.
  - On dmem_ack, sw: pc_en=1 and pc_sel=0, then FETCH.
  - Timeout works as in FETCH, with cause 3.
- WB: rf_we=write_reg flag and pc_en=1, then FETCH.
  - wb_sel: 2 for jal, 1 for lw, 0 otherwise.
  - pc_sel: 1 for jal, 0 otherwise.
- TRAP: terminal until reset.
  - halt=1, trap_cause is held, all strobes are 0, and acks are ignored.
- Acks outside their request state are ignored.
- dmem_req, imem_req, ir_en, rf_we and pc_en are never asserted in the same cycle as a different request.
- Latency, with ack in the first request cycle:
  - ALU/jal: 4 cycles FETCH..WB.
  - branch: 3 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
- wait_cnt width is $clog2(MEM_TIMEOUT+1). With MEM_TIMEOUT=0 the core waits forever.

Optional Feature:
PERF_CNT_EN.
- Defined:
  - cycles increments every cycle when not in BOOT or TRAP.
  - instret increments on each cycle with pc_en=1.
  - Both wrap from 2^32-1 to 0.
  - Both clear on reset.
- Undefined: both ports are driven constant 0 and the counter registers are absent.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum;
  - the ALUop constants (OP_JAL, OP_BEQ, OP_BLT, OP_LW, OP_SW, OP_ILLEGAL);
  - the WB_ALU/WB_MEM/WB_LINK constants;
  - the TRAP_* cause codes.
- One sub-module, mem_wait_timer: wait_cnt with clear, enable and a timeout flag, shared by FETCH and MEM.

Test Plan:
1. Release rst, drive alu_op=01100 (addi) with write_reg=1 and imem_ack in the first FETCH cycle -> state sequence 0,1,2,3,5,1. In WB: rf_we=1, wb_sel=0, pc_en=1, pc_sel=0. instret=1 with PERF_CNT_EN.
2. lw (10100), dmem_ack delayed 3 cycles -> dmem_req high for 4 MEM cycles and dmem_we=0. Then WB with rf_we=1 and wb_sel=1.
3. sw (10101), dmem_ack immediately -> dmem_we=1, and pc_en=1 with pc_sel=0 in the same MEM cycle. rf_we stays 0 throughout. Next state is FETCH.
4. beq (10001) -> pc_en=1 and pc_sel=1 in EXEC, then FETCH; no WB state. jal (10000) -> WB with wb_sel=2 and pc_sel=1.
5. alu_op=00000 -> TRAP after DECODE with halt=1 and trap_cause=2. Both are held for 20 cycles with acks toggling and all strobes 0. Driving rst low clears them immediately.
6. MEM_TIMEOUT=8, imem_ack never asserted -> TRAP with cause 1 after exactly 8 FETCH cycles. Repeat with ack on the 8th cycle -> DECODE, no trap.
